simd_wave_sequencer: RTL and testbench
======================================

// Module: simd_wave_sequencer
// PURPOSE
//  Multi-wave issue sequencer for a SIMD unit: holds up to NUM_SLOTS resident wavefronts, each with its own PC.
//  Picks waves round-robin, fetches one instruction per wave, then issues it over ceil(WAVE_SIZE/LANE_WIDTH)
//  wave cycles with a per-lane active mask and base thread id. Sits between the wave dispatcher, fetcher and lane datapath.
// PARAMETERS
//  LANE_WIDTH              16  lanes per wave cycle
//  WAVE_SIZE               32  threads per wave; CYCLES = ceil(WAVE_SIZE/LANE_WIDTH)
//  NUM_SLOTS                4  resident wave slots; SW = max(1,clog2(NUM_SLOTS))
//  PROGRAM_MEM_ADDR_WIDTH   6  PC width (PW)
//  INSTRUCTION_WIDTH       32  instruction width (IW)
// PORTS
//  clk             in   1      clock
//  rst             in   1      asynchronous reset, active-low
//  enable          in   1      0: no new dispatch accepted, no new wave selected
//  block_dim       in   32     threads per block
//  disp_valid      in   1      dispatcher offers a wave
//  disp_ready      out  1      a slot is free and enable=1
//  disp_block_id   in   32     block id of offered wave
//  disp_wave_id    in   32     wave id within block
//  disp_pc         in   PW     start PC
//  fetch_req_valid out  1      instruction fetch request
//  fetch_req_addr  out  PW     PC of selected wave
//  fetch_ack       in   1      fetch complete; fetch_instr valid this cycle
//  fetch_instr     in   IW     fetched instruction
//  issue_valid     out  1      one wave cycle offered to lanes
//  issue_ready     in   1      lanes accept
//  issue_instr     out  IW     instruction
//  issue_slot      out  SW     slot of issuing wave
//  issue_cycle     out  max(1,clog2(CYCLES))  wave cycle index
//  issue_mask      out  LANE_WIDTH  active lanes
//  issue_base_tid  out  32     global thread id of lane 0
//  exec_done       in   1      lanes finished instruction
//  exec_ret        in   1      with exec_done: instruction was RET
//  exec_branch     in   1      with exec_done: branch taken
//  exec_branch_pc  in   PW     branch target
//  wave_done       out  1      1-cycle pulse: a wave retired
//  wave_done_slot  out  SW     retired slot
//  busy            out  1      any slot valid or FSM not IDLE
// BEHAVIOUR
//  - Reset (rst=0, async): all slots invalid, RR pointer 0, FSM IDLE, every output 0. Mid-operation reset aborts all.
//  - Dispatch: disp_valid&&disp_ready at edge T writes lowest-index free slot; slot valid from T+1. disp_ready is
//    combinational from registered slot state; a slot freed at edge T is offered from T+1, never same cycle.
//  - FSM: IDLE->SELECT when any slot valid and enable. SELECT: RR pick, first valid slot after last issued (wrapping).
//    SELECT->FETCH registers fetch_req_valid/addr=PC (visible next cycle). fetch_req_valid held until fetch_ack;
//    FETCH->ISSUE latches fetch_instr. ISSUE: issue_valid held, fields stable, until issue_ready; then next cycle.
//    After last non-empty cycle -> WAIT. WAIT on exec_done: ret -> free slot, wave_done pulse next cycle;
//    else PC<=exec_branch?exec_branch_pc:PC+1 (mod 2^PW); then SELECT if any slot valid and enable, else IDLE.
//  - Lane l, cycle c: t = wave_id*WAVE_SIZE + c*LANE_WIDTH + l; active iff c*LANE_WIDTH+l < WAVE_SIZE and t < block_dim.
//    issue_base_tid = block_id*block_dim + wave_id*WAVE_SIZE + c*LANE_WIDTH, 32-bit truncating.
//  - Cycles with all-zero mask are skipped. Wave with all cycles empty retires in SELECT without fetch
//    (wave_done pulse next cycle), RR advances.
//  - exec_ret and exec_branch both set: ret wins. exec_done outside WAIT ignored. fetch_ack outside FETCH ignored.
//  - enable=0 holds FSM in IDLE/SELECT only; in-flight FETCH/ISSUE/WAIT completes.
// TESTING
//  1. block_dim=32, disp wave0 blk2 pc=5 -> fetch addr 5; ack 0xA; issues c0 mask FFFF tid 64, c1 FFFF tid 80;
//     exec_done+exec_ret -> wave_done slot0, busy 0.
//  2. block_dim=20 wave0 -> c1 mask 000F; block_dim=40 wave1 -> c0 mask 00FF, c1 skipped (one issue only).
//  3. Three waves pc 0,10,20 no ret -> fetch addrs 0,10,20,1,11,21 (RR order, PC+1).
//  4. Fill 4 slots -> disp_ready 0; retire slot2 -> disp_ready 1 next cycle; next dispatch lands in slot2.
//  5. pc=63 no branch -> next fetch 0; exec_branch pc=7 with exec_ret -> retires, no fetch at 7.
//  6. rst low during ISSUE with issue_ready=0 -> all outputs 0 immediately, disp_ready 1 after release with enable=1.

Source files
------------

// File: rtl/simd_wave_sequencer.sv
// Multi-wave SIMD issue sequencer: resident wave slots, round-robin pick, one fetch per
// instruction, then issue over the non-empty wave cycles with per-lane masks.
module simd_wave_sequencer #(
  parameter int LANE_WIDTH             = 16,
  parameter int WAVE_SIZE              = 32,
  parameter int NUM_SLOTS              = 4,
  parameter int PROGRAM_MEM_ADDR_WIDTH = 6,
  parameter int INSTRUCTION_WIDTH      = 32,
  localparam int PW     = PROGRAM_MEM_ADDR_WIDTH,
  localparam int IW     = INSTRUCTION_WIDTH,
  localparam int CYCLES = (WAVE_SIZE + LANE_WIDTH - 1) / LANE_WIDTH,
  localparam int SW     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [31:0]           block_dim,
  input  logic                  disp_valid,
  output logic                  disp_ready,
  input  logic [31:0]           disp_block_id,
  input  logic [31:0]           disp_wave_id,
  input  logic [PW-1:0]         disp_pc,
  output logic                  fetch_req_valid,
  output logic [PW-1:0]         fetch_req_addr,
  input  logic                  fetch_ack,
  input  logic [IW-1:0]         fetch_instr,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [IW-1:0]         issue_instr,
  output logic [SW-1:0]         issue_slot,
  output logic [CW-1:0]         issue_cycle,
  output logic [LANE_WIDTH-1:0] issue_mask,
  output logic [31:0]           issue_base_tid,
  input  logic                  exec_done,
  input  logic                  exec_ret,
  input  logic                  exec_branch,
  input  logic [PW-1:0]         exec_branch_pc,
  output logic                  wave_done,
  output logic [SW-1:0]         wave_done_slot,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the offering side holds valid and its payload stable until that edge.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_SELECT = 3'd1, S_FETCH = 3'd2, S_ISSUE = 3'd3, S_WAIT = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_SLOTS-1:0]  valid_q, valid_d;
  logic [PW-1:0]         pc_q  [NUM_SLOTS];
  logic [PW-1:0]         pc_d  [NUM_SLOTS];
  logic [31:0]           blk_q [NUM_SLOTS];
  logic [31:0]           blk_d [NUM_SLOTS];
  logic [31:0]           wid_q [NUM_SLOTS];
  logic [31:0]           wid_d [NUM_SLOTS];
  logic [SW-1:0]         rr_q, rr_d, cur_q, cur_d, done_slot_q, done_slot_d;
  logic [CW-1:0]         cyc_q, cyc_d;
  logic [IW-1:0]         instr_q, instr_d;
  logic                  fetch_valid_q, fetch_valid_d, done_q, done_d;
  logic [PW-1:0]         fetch_addr_q, fetch_addr_d;

  logic                  any_free, found, pick_live, has_next;
  logic [SW-1:0]         free_idx, pick, rr_ix;
  logic [CW-1:0]         first_cyc, next_cyc;
  logic [LANE_WIDTH-1:0] cur_mask;

  // Lane l of cycle c is live when it lies inside the wave and its thread exists in the block.
  function automatic logic [LANE_WIDTH-1:0] lane_mask(input logic [31:0] wid, input int c,
                                                       input logic [31:0] bdim);
    logic [63:0] t;
    int          idx;
    lane_mask = '0;
    for (int l = 0; l < LANE_WIDTH; l++) begin
      idx = c * LANE_WIDTH + l;
      t   = 64'(wid) * 64'(WAVE_SIZE) + 64'(idx);
      lane_mask[l] = (idx < WAVE_SIZE) && (t < 64'(bdim));
    end
  endfunction

  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        any_free = 1'b1;
        free_idx = SW'(i);
      end
    end
    found = 1'b0;
    pick  = '0;
    rr_ix = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      rr_ix = SW'((int'(rr_q) + i) % NUM_SLOTS);
      if (!found && valid_q[rr_ix]) begin
        found = 1'b1;
        pick  = rr_ix;
      end
    end
    pick_live = 1'b0;
    for (int c = 0; c < CYCLES; c++) begin
      if (|lane_mask(wid_q[pick], c, block_dim)) pick_live = 1'b1;
    end
    // Scanning downward leaves the lowest matching cycle in each result.
    first_cyc = '0;
    next_cyc  = '0;
    has_next  = 1'b0;
    for (int c = CYCLES - 1; c >= 0; c--) begin
      if (|lane_mask(wid_q[cur_q], c, block_dim)) begin
        first_cyc = CW'(c);
        if (c > int'(cyc_q)) begin
          next_cyc = CW'(c);
          has_next = 1'b1;
        end
      end
    end
    cur_mask = lane_mask(wid_q[cur_q], int'(cyc_q), block_dim);
  end

  assign disp_ready = rst & enable & any_free;

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    pc_d          = pc_q;
    blk_d         = blk_q;
    wid_d         = wid_q;
    rr_d          = rr_q;
    cur_d         = cur_q;
    cyc_d         = cyc_q;
    instr_d       = instr_q;
    fetch_valid_d = fetch_valid_q;
    fetch_addr_d  = fetch_addr_q;
    done_d        = 1'b0;
    done_slot_d   = done_slot_q;

    if (disp_valid && disp_ready) begin
      valid_d[free_idx] = 1'b1;
      pc_d[free_idx]    = disp_pc;
      blk_d[free_idx]   = disp_block_id;
      wid_d[free_idx]   = disp_wave_id;
    end

    case (state_q)
      S_IDLE: if (enable && (|valid_q)) state_d = S_SELECT;
      S_SELECT: begin
        if (!(|valid_q)) begin
          state_d = S_IDLE;
        end else if (enable && found) begin
          cur_d = pick;
          rr_d  = (int'(pick) + 1 >= NUM_SLOTS) ? '0 : SW'(int'(pick) + 1);
          if (!pick_live) begin
            valid_d[pick] = 1'b0;
            done_d        = 1'b1;
            done_slot_d   = pick;
          end else begin
            fetch_valid_d = 1'b1;
            fetch_addr_d  = pc_q[pick];
            state_d       = S_FETCH;
          end
        end
      end
      S_FETCH: if (fetch_ack) begin
        instr_d       = fetch_instr;
        fetch_valid_d = 1'b0;
        cyc_d         = first_cyc;
        state_d       = S_ISSUE;
      end
      S_ISSUE: if (issue_ready) begin
        if (has_next) cyc_d = next_cyc;
        else          state_d = S_WAIT;
      end
      S_WAIT: if (exec_done) begin
        if (exec_ret) begin
          valid_d[cur_q] = 1'b0;
          done_d         = 1'b1;
          done_slot_d    = cur_q;
        end else begin
          pc_d[cur_q] = exec_branch ? exec_branch_pc : pc_q[cur_q] + PW'(1);
        end
        state_d = ((|valid_d) && enable) ? S_SELECT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      valid_q       <= '0;
      rr_q          <= '0;
      cur_q         <= '0;
      cyc_q         <= '0;
      instr_q       <= '0;
      fetch_valid_q <= 1'b0;
      fetch_addr_q  <= '0;
      done_q        <= 1'b0;
      done_slot_q   <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        pc_q[i]  <= '0;
        blk_q[i] <= '0;
        wid_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      rr_q          <= rr_d;
      cur_q         <= cur_d;
      cyc_q         <= cyc_d;
      instr_q       <= instr_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_addr_q  <= fetch_addr_d;
      done_q        <= done_d;
      done_slot_q   <= done_slot_d;
      pc_q          <= pc_d;
      blk_q         <= blk_d;
      wid_q         <= wid_d;
    end
  end

  assign fetch_req_valid = fetch_valid_q;
  assign fetch_req_addr  = fetch_addr_q;
  assign issue_valid     = (state_q == S_ISSUE);
  assign issue_instr     = issue_valid ? instr_q : '0;
  assign issue_slot      = issue_valid ? cur_q : '0;
  assign issue_cycle     = issue_valid ? cyc_q : '0;
  assign issue_mask      = issue_valid ? cur_mask : '0;
  assign issue_base_tid  = issue_valid ? (blk_q[cur_q] * block_dim + wid_q[cur_q] * 32'(WAVE_SIZE)
                                          + 32'(int'(cyc_q) * LANE_WIDTH)) : '0;
  assign wave_done       = done_q;
  assign wave_done_slot  = done_slot_q;
  assign busy            = (|valid_q) || (state_q != S_IDLE);
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_simd_wave_sequencer.sv
// Directed bench for simd_wave_sequencer: tasks play dispatcher, fetcher and lanes while
// monitors compare fetches, issues and retirements against expected queues.
module tb_simd_wave_sequencer;
  localparam int IVW = 2 + 1 + 16 + 32 + 32;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [31:0] block_dim;
  logic        disp_valid, disp_ready;
  logic [31:0] disp_block_id, disp_wave_id;
  logic [5:0]  disp_pc;
  logic        fetch_req_valid, fetch_ack;
  logic [5:0]  fetch_req_addr;
  logic [31:0] fetch_instr;
  logic        issue_valid, issue_ready;
  logic [31:0] issue_instr, issue_base_tid;
  logic [1:0]  issue_slot;
  logic        issue_cycle;
  logic [15:0] issue_mask;
  logic        exec_done, exec_ret, exec_branch;
  logic [5:0]  exec_branch_pc;
  logic        wave_done, busy;
  logic [1:0]  wave_done_slot;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0]     exp_fetch_q[$];
  logic [IVW-1:0] exp_issue_q[$];
  logic [1:0]     exp_done_q[$];

  int t3_pc  [9] = '{0, 10, 20, 1, 11, 21, 2, 12, 22};
  int t4_pc  [7] = '{30, 31, 32, 33, 31, 32, 40};
  int t4_slot[7] = '{0, 1, 2, 3, 0, 1, 2};
  int t4_tid [7] = '{0, 32, 64, 96, 0, 32, 128};
  int t4_ret [7] = '{0, 0, 1, 1, 1, 1, 1};
  int t4_done[5] = '{2, 3, 0, 1, 2};

  simd_wave_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable), .block_dim(block_dim),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_block_id(disp_block_id),
    .disp_wave_id(disp_wave_id), .disp_pc(disp_pc),
    .fetch_req_valid(fetch_req_valid), .fetch_req_addr(fetch_req_addr),
    .fetch_ack(fetch_ack), .fetch_instr(fetch_instr),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
    .issue_slot(issue_slot), .issue_cycle(issue_cycle), .issue_mask(issue_mask),
    .issue_base_tid(issue_base_tid),
    .exec_done(exec_done), .exec_ret(exec_ret), .exec_branch(exec_branch),
    .exec_branch_pc(exec_branch_pc),
    .wave_done(wave_done), .wave_done_slot(wave_done_slot), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard helpers
  task automatic push_iss(input logic [1:0] slot, input logic cyc, input logic [15:0] mask,
                          input logic [31:0] tid, input logic [31:0] instr);
    exp_issue_q.push_back({slot, cyc, mask, tid, instr});
  endtask

  task automatic push_full(input logic [1:0] slot, input logic [31:0] tid0, input logic [31:0] instr);
    push_iss(slot, 1'b0, 16'hFFFF, tid0, instr);
    push_iss(slot, 1'b1, 16'hFFFF, tid0 + 32'd16, instr);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      if (exp_fetch_q.size() == 0) begin
        if (fetch_req_valid) check("fetch_unexpected", fetch_req_valid, 1'b0);
      end else if (fetch_req_valid && fetch_ack) begin
        check("fetch_addr", fetch_req_addr, exp_fetch_q.pop_front());
      end
      if (issue_valid && issue_ready) begin
        if (exp_issue_q.size() == 0) check("issue_unexpected", issue_valid, 1'b0);
        else check("issue", {issue_slot, issue_cycle, issue_mask, issue_base_tid, issue_instr},
                   exp_issue_q.pop_front());
      end
      if (wave_done) begin
        if (exp_done_q.size() == 0) check("done_unexpected", wave_done, 1'b0);
        else check("wave_done_slot", wave_done_slot, exp_done_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic do_dispatch(input logic [31:0] blk, input logic [31:0] wid, input logic [5:0] pc);
    bit ok = 0;
    @(posedge clk); #1;
    disp_valid = 1'b1; disp_block_id = blk; disp_wave_id = wid; disp_pc = pc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (disp_ready) begin ok = 1; break; end
    end
    if (!ok) check("dispatch_timeout", disp_ready, 1'b1);
    @(posedge clk); #1;
    disp_valid = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] instr);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fetch_req_valid) begin ok = 1; break; end
    end
    if (!ok) check("fetch_timeout", fetch_req_valid, 1'b1);
    @(posedge clk); #1;
    fetch_ack = 1'b1; fetch_instr = instr;
    @(posedge clk); #1;
    fetch_ack = 1'b0;
  endtask

  task automatic do_issue(input int n);
    int cnt = 0;
    bit ok = 0;
    @(posedge clk); #1;
    issue_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (issue_valid) begin
        cnt++;
        if (cnt == n) begin ok = 1; break; end
      end
    end
    if (!ok) check("issue_timeout", issue_valid, 1'b1);
    @(posedge clk); #1;
    issue_ready = 1'b0;
  endtask

  task automatic do_exec(input bit ret, input bit br, input logic [5:0] bpc, input bit chk_ready);
    @(posedge clk); #1;
    exec_done = 1'b1; exec_ret = ret; exec_branch = br; exec_branch_pc = bpc;
    if (chk_ready) begin
      @(negedge clk);
      check("disp_ready_before_free", disp_ready, 1'b0);
    end
    @(posedge clk); #1;
    exec_done = 1'b0; exec_ret = 1'b0; exec_branch = 1'b0; exec_branch_pc = '0;
    if (chk_ready) begin
      @(negedge clk);
      check("disp_ready_after_free", disp_ready, 1'b1);
    end
  endtask

  task automatic run_instr(input logic [31:0] instr, input int n, input bit ret, input bit br,
                           input logic [5:0] bpc);
    do_fetch(instr);
    do_issue(n);
    do_exec(ret, br, bpc, 1'b0);
  endtask

  function automatic logic [98:0] all_outs();
    return {disp_ready, fetch_req_valid, fetch_req_addr, issue_valid, issue_instr, issue_slot,
            issue_cycle, issue_mask, issue_base_tid, wave_done, wave_done_slot, busy, dbg_state};
  endfunction

  initial begin
    bit ok;
    rst = 1'b0; enable = 1'b1; block_dim = 32'd32;
    disp_valid = 1'b0; disp_block_id = '0; disp_wave_id = '0; disp_pc = '0;
    fetch_ack = 1'b0; fetch_instr = '0; issue_ready = 1'b0;
    exec_done = 1'b0; exec_ret = 1'b0; exec_branch = 1'b0; exec_branch_pc = '0;
    #2;
    check("reset_outputs", all_outs(), '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", disp_ready, 1'b1);

    // 1: one full wave, block 2, pc 5
    exp_fetch_q.push_back(6'd5);
    push_full(2'd0, 32'd64, 32'hA);
    exp_done_q.push_back(2'd0);
    do_dispatch(32'd2, 32'd0, 6'd5);
    run_instr(32'hA, 2, 1'b1, 1'b0, 6'd0);
    @(negedge clk);
    check("t1_busy", busy, 1'b0);

    // 2: partial masks and a skipped empty cycle
    @(posedge clk); #1; block_dim = 32'd20;
    exp_fetch_q.push_back(6'd0);
    push_iss(2'd0, 1'b0, 16'hFFFF, 32'd0, 32'h14);
    push_iss(2'd0, 1'b1, 16'h000F, 32'd16, 32'h14);
    exp_done_q.push_back(2'd0);
    do_dispatch(32'd0, 32'd0, 6'd0);
    run_instr(32'h14, 2, 1'b1, 1'b0, 6'd0);
    @(posedge clk); #1; block_dim = 32'd40;
    exp_fetch_q.push_back(6'd3);
    push_iss(2'd0, 1'b0, 16'h00FF, 32'd72, 32'h28);
    exp_done_q.push_back(2'd0);
    do_dispatch(32'd1, 32'd1, 6'd3);
    do_fetch(32'h28);
    do_issue(1);
    @(negedge clk);
    check("t2_c1_skipped", issue_valid, 1'b0);
    do_exec(1'b1, 1'b0, 6'd0, 1'b0);
    @(negedge clk);
    check("t2_busy", busy, 1'b0);

    // 3: round-robin over three waves with PC+1
    @(posedge clk); #1; block_dim = 32'd96;
    for (int k = 0; k < 9; k++) begin
      exp_fetch_q.push_back(6'(t3_pc[k]));
      push_full(2'(k % 3), 32'((k % 3) * 32), 32'h1000 + 32'(t3_pc[k]));
    end
    exp_done_q.push_back(2'd0); exp_done_q.push_back(2'd1); exp_done_q.push_back(2'd2);
    do_dispatch(32'd0, 32'd0, 6'd0);
    do_dispatch(32'd0, 32'd1, 6'd10);
    do_dispatch(32'd0, 32'd2, 6'd20);
    for (int k = 0; k < 9; k++) run_instr(32'h1000 + 32'(t3_pc[k]), 2, k >= 6, 1'b0, 6'd0);
    @(negedge clk);
    check("t3_busy", busy, 1'b0);

    // 4: full slots, free slot 2, refill lands in slot 2
    @(posedge clk); #1; block_dim = 32'd160;
    for (int k = 0; k < 7; k++) begin
      exp_fetch_q.push_back(6'(t4_pc[k]));
      push_full(2'(t4_slot[k]), 32'(t4_tid[k]), 32'h1000 + 32'(t4_pc[k]));
    end
    for (int k = 0; k < 5; k++) exp_done_q.push_back(2'(t4_done[k]));
    for (int k = 0; k < 4; k++) do_dispatch(32'd0, 32'(k), 6'(30 + k));
    @(negedge clk);
    check("t4_full_not_ready", disp_ready, 1'b0);
    for (int k = 0; k < 7; k++) begin
      do_fetch(32'h1000 + 32'(t4_pc[k]));
      do_issue(2);
      do_exec(t4_ret[k] != 0, 1'b0, 6'd0, k == 2);
      if (k == 2) do_dispatch(32'd0, 32'd4, 6'd40);
    end
    @(negedge clk);
    check("t4_busy", busy, 1'b0);

    // 5: PC wrap, then ret beats branch
    @(posedge clk); #1; block_dim = 32'd32;
    exp_fetch_q.push_back(6'd63);
    exp_fetch_q.push_back(6'd0);
    push_full(2'd0, 32'd0, 32'h103F);
    push_full(2'd0, 32'd0, 32'h1000);
    exp_done_q.push_back(2'd0);
    do_dispatch(32'd0, 32'd0, 6'd63);
    run_instr(32'h103F, 2, 1'b0, 1'b0, 6'd0);
    run_instr(32'h1000, 2, 1'b1, 1'b1, 6'd7);
    repeat (4) @(negedge clk);
    check("t5_no_fetch", fetch_req_valid, 1'b0);
    check("t5_busy", busy, 1'b0);

    // 6: reset while an issue is held
    @(posedge clk); #1; block_dim = 32'd64;
    exp_fetch_q.push_back(6'd9);
    do_dispatch(32'd3, 32'd1, 6'd9);
    do_fetch(32'h55);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (issue_valid) begin ok = 1; break; end
    end
    check("t6_issue_present", issue_valid, 1'b1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("t6_reset_outputs", all_outs(), '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("t6_ready_after", disp_ready, 1'b1);
    check("t6_busy_after", busy, 1'b0);
    @(posedge clk); #1; enable = 1'b0;
    @(negedge clk);
    check("t6_ready_disabled", disp_ready, 1'b0);
    @(posedge clk); #1; enable = 1'b1;
    exp_fetch_q.push_back(6'd9);
    push_full(2'd0, 32'd224, 32'h66);
    exp_done_q.push_back(2'd0);
    do_dispatch(32'd3, 32'd1, 6'd9);
    run_instr(32'h66, 2, 1'b1, 1'b0, 6'd0);
    @(negedge clk);
    check("t6_busy_end", busy, 1'b0);

    // Report
    repeat (5) @(negedge clk);
    check("fetch_left", exp_fetch_q.size(), 0);
    check("issue_left", exp_issue_q.size(), 0);
    check("done_left", exp_done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
